// File: rtl/reflet_mem_responder.sv
// rtl/reflet_mem_responder.sv - word-addressed RAM responder with req/ready/ack handshake and wait states
module reflet_mem_responder #(
  parameter int word_size   = 64,
  parameter int addr_size   = 64,
  parameter int depth       = 8,
  parameter int wait_states = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [addr_size-1:0] addr,
  input  logic                 write_en,
  input  logic [word_size-1:0] data_in,
  output logic [word_size-1:0] data_out,
  output logic                 ready,
  output logic                 ack,
  output logic                 err
);

  localparam int off_bits = $clog2(word_size / 8);
  localparam int idx_bits = addr_size - off_bits;
  localparam int mem_bits = $clog2(depth);
  localparam logic [3:0] wait_load = 4'(wait_states - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic                 ready_next;
  logic                 accept;
  logic                 access;
  logic                 from_latch;

  logic [addr_size-1:0] addr_q;
  logic                 we_q;
  logic [word_size-1:0] data_q;

  logic [addr_size-1:0] acc_addr;
  logic                 acc_we;
  logic [word_size-1:0] acc_data;
  logic [idx_bits-1:0]  acc_idx;
  logic                 out_of_range;
  logic                 unused_offset;

  // Backing store; contents survive reset and start out as zero.
  logic [word_size-1:0] mem [depth] = '{default: '0};

  // With no wait states the access uses the live inputs on the accept edge;
  // otherwise it uses the copy latched at accept time.
  assign acc_addr      = from_latch ? addr_q : addr;
  assign acc_we        = from_latch ? we_q   : write_en;
  assign acc_data      = from_latch ? data_q : data_in;
  assign acc_idx       = acc_addr[addr_size-1:off_bits];
  assign out_of_range  = acc_idx >= idx_bits'(depth);
  assign unused_offset = ^acc_addr[off_bits-1:0];

  // Next-state logic: accept in IDLE, count down in WAIT, complete on cnt == 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_next = ready;
    accept     = 1'b0;
    access     = 1'b0;
    from_latch = 1'b0;
    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (ready && req) begin
          accept = 1'b1;
          if (wait_states == 0) begin
            access = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = wait_load;
            ready_next = 1'b0;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access     = 1'b1;
          from_latch = 1'b1;
          state_next = IDLE;
          ready_next = 1'b1;
        end
      end
    endcase
  end

  // State register; reset drops any pending access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= ready_next;
    end
  end

  // Capture the request so the delayed access sees the accepted values.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr;
      we_q   <= write_en;
      data_q <= data_in;
    end
  end

  // Completion outputs: read-before-write data, one-cycle ack/err pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack      <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      ack <= access;
      err <= access && out_of_range;
      if (access) begin
        data_out <= out_of_range ? '0 : mem[acc_idx[mem_bits-1:0]];
      end
    end
  end

  // Memory write, suppressed for out-of-range indices and while in reset.
  always_ff @(posedge clk) begin
    if (reset && access && acc_we && !out_of_range) begin
      mem[acc_idx[mem_bits-1:0]] <= acc_data;
    end
  end

endmodule

// File: tb/tb_reflet_mem_responder.sv
// tb/tb_reflet_mem_responder.sv - scoreboard bench for reflet_mem_responder (W=0 and W=3 instances)
module tb_reflet_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_a, we_a, ready_a, ack_a, err_a;
  logic [63:0] addr_a, din_a, dout_a;
  logic        req_b, we_b, ready_b, ack_b, err_b;
  logic [63:0] addr_b, din_b, dout_b;

  reflet_mem_responder #(.word_size(64), .addr_size(64), .depth(8), .wait_states(0)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .addr(addr_a), .write_en(we_a),
    .data_in(din_a), .data_out(dout_a), .ready(ready_a), .ack(ack_a), .err(err_a));

  reflet_mem_responder #(.word_size(64), .addr_size(64), .depth(8), .wait_states(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .addr(addr_b), .write_en(we_b),
    .data_in(din_b), .data_out(dout_b), .ready(ready_b), .ack(ack_b), .err(err_b));

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [63:0] model_a [8];
  logic [63:0] model_b [8];
  int          checks   = 0;
  int          failures = 0;

  task automatic issue_a(input logic [63:0] a, input logic we, input logic [63:0] d);
    exp_t e;
    logic [60:0] idx;
    idx = a[63:3];
    if (idx < 61'd8) begin
      e.data = model_a[idx[2:0]];
      e.err  = 1'b0;
      if (we) model_a[idx[2:0]] = d;
    end else begin
      e.data = 64'h0;
      e.err  = 1'b1;
    end
    q_a.push_back(e);
    req_a = 1'b1; addr_a = a; we_a = we; din_a = d;
  endtask

  task automatic issue_b(input logic [63:0] a, input logic we, input logic [63:0] d);
    exp_t e;
    logic [60:0] idx;
    idx = a[63:3];
    if (idx < 61'd8) begin
      e.data = model_b[idx[2:0]];
      e.err  = 1'b0;
      if (we) model_b[idx[2:0]] = d;
    end else begin
      e.data = 64'h0;
      e.err  = 1'b1;
    end
    q_b.push_back(e);
    req_b = 1'b1; addr_b = a; we_b = we; din_b = d;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_a = 1'b0; addr_a = '0; we_a = 1'b0; din_a = '0;
    req_b = 1'b0; addr_b = '0; we_b = 1'b0; din_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready_a got=%b exp=0", ready_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack_a got=%b exp=0", ack_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err_a got=%b exp=0", err_a); end
    checks++; if (dout_a !== 64'h0) begin failures++; $display("FAIL reset_dout_a got=%h exp=0", dout_a); end
    checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL reset_ready_b got=%b exp=0", ready_b); end
    // Request in the first cycle after reset must be ignored (ready still 0).
    reset = 1'b1;
    req_a = 1'b1; addr_a = 64'h0; we_a = 1'b1; din_a = 64'h99;
    @(negedge clk);
    req_a = 1'b0;
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL first_cycle_req_ack got=%b exp=0", ack_a); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL post_reset_ready_a got=%b exp=1", ready_a); end
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL post_reset_ready_b got=%b exp=1", ready_b); end
  endtask

  task automatic test_w0_basic;
    logic [63:0] ta [6];
    logic        tw [6];
    logic [63:0] td [6];
    exp_t        e;
    ta = '{64'd0, 64'd0, 64'd8, 64'd13, 64'd8, 64'd8};
    tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    td = '{64'h1212121212121212, 64'h0, 64'hABABABABABABABAB, 64'h0, 64'hFDFDFDFDFDFDFDFD, 64'h0};
    for (int i = 0; i < 6; i++) begin
      issue_a(ta[i], tw[i], td[i]);
      @(negedge clk);
      checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL w0_ack op%0d got=%b exp=1", i, ack_a); end
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL w0_ready op%0d got=%b exp=1", i, ready_a); end
      e = q_a.pop_front();
      checks++; if (dout_a !== e.data) begin failures++; $display("FAIL w0_data op%0d got=%h exp=%h", i, dout_a, e.data); end
      checks++; if (err_a !== e.err) begin failures++; $display("FAIL w0_err op%0d got=%b exp=%b", i, err_a, e.err); end
    end
    req_a = 1'b0;
    @(negedge clk);
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL w0_ack_clear got=%b exp=0", ack_a); end
    checks++; if (dout_a !== 64'hFDFDFDFDFDFDFDFD) begin failures++; $display("FAIL w0_dout_held got=%h exp=fdfdfdfdfdfdfdfd", dout_a); end
  endtask

  task automatic test_out_of_range;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      issue_a(64'd64, 1'b1, 64'h55);
      else if (i == 1) issue_a(64'd64, 1'b0, 64'h0);
      else             issue_a(64'((i - 2) * 8), 1'b0, 64'h0);
      @(negedge clk);
      checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL oor_ack op%0d got=%b exp=1", i, ack_a); end
      e = q_a.pop_front();
      checks++; if (dout_a !== e.data) begin failures++; $display("FAIL oor_data op%0d got=%h exp=%h", i, dout_a, e.data); end
      checks++; if (err_a !== e.err) begin failures++; $display("FAIL oor_err op%0d got=%b exp=%b", i, err_a, e.err); end
    end
    req_a = 1'b0;
    @(negedge clk);
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", err_a); end
  endtask

  task automatic test_wait_states;
    exp_t e;
    int   lat;
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL ws_ready_idle got=%b exp=1", ready_b); end
    issue_b(64'd0, 1'b1, 64'h3333333333333333);
    // Accept edge passes; a competing request while busy must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_b = 1'b1; addr_b = 64'd8; we_b = 1'b1; din_b = 64'hDEAD;
      checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL ws_ready_low cyc%0d got=%b exp=0", i, ready_b); end
      checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL ws_early_ack cyc%0d got=%b exp=0", i, ack_b); end
    end
    req_b = 1'b0;
    @(negedge clk);
    checks++; if (ack_b !== 1'b1) begin failures++; $display("FAIL ws_ack got=%b exp=1", ack_b); end
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL ws_ready_back got=%b exp=1", ready_b); end
    e = q_b.pop_front();
    checks++; if (dout_b !== e.data) begin failures++; $display("FAIL ws_data got=%h exp=%h", dout_b, e.data); end
    checks++; if (err_b !== e.err) begin failures++; $display("FAIL ws_err got=%b exp=%b", err_b, e.err); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL ws_extra_ack got=%b exp=0", ack_b); end
    end
    issue_b(64'd0, 1'b0, 64'h0);
    @(negedge clk);
    req_b = 1'b0;
    lat = 1;
    while (ack_b !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 4) begin failures++; $display("FAIL ws_latency got=%0d exp=4", lat); end
    e = q_b.pop_front();
    checks++; if (dout_b !== e.data) begin failures++; $display("FAIL ws_readback got=%h exp=%h", dout_b, e.data); end
    checks++; if (dout_b !== 64'h3333333333333333) begin failures++; $display("FAIL ws_readback_const got=%h exp=3333333333333333", dout_b); end
  endtask

  task automatic test_reset_during_wait;
    exp_t e;
    int   lat;
    @(negedge clk);
    req_b = 1'b1; addr_b = 64'd0; we_b = 1'b1; din_b = 64'h77;
    @(negedge clk);
    req_b = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL rdw_ack_in_reset got=%b exp=0", ack_b); end
    checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL rdw_ready_in_reset got=%b exp=0", ready_b); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL rdw_ready_after got=%b exp=1", ready_b); end
    repeat (4) begin
      checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL rdw_dropped_ack got=%b exp=0", ack_b); end
      @(negedge clk);
    end
    issue_b(64'd0, 1'b0, 64'h0);
    @(negedge clk);
    req_b = 1'b0;
    lat = 1;
    while (ack_b !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (ack_b !== 1'b1) begin failures++; $display("FAIL rdw_read_ack got=%b exp=1 after %0d cycles", ack_b, lat); end
    e = q_b.pop_front();
    checks++; if (dout_b !== e.data) begin failures++; $display("FAIL rdw_old_value got=%h exp=%h", dout_b, e.data); end
  endtask

  initial begin
    foreach (model_a[i]) model_a[i] = 64'h0;
    foreach (model_b[i]) model_b[i] = 64'h0;
    test_reset();
    test_w0_basic();
    test_out_of_range();
    test_wait_states();
    test_reset_during_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
